// File: rtl/umpy_accum_if.sv
// Handshake/data bundle between a umpy_NxM product stream and umpy_accum.
// The master drives the product stream and the slave (the accumulator) returns frame results.
interface umpy_accum_if #(
   parameter int unsigned NP    = 24,
   parameter int unsigned OW    = 16,
   parameter int unsigned LGCNT = 8
) ();
   logic             i_ce;
   logic [NP-1:0]    i_p;
   logic             i_aux;
   logic             i_flush;
   logic [OW-1:0]    o_sum;
   logic [LGCNT-1:0] o_cnt;
   logic             o_ovf;
   logic             o_valid;

   modport master (
      output i_ce, i_p, i_aux, i_flush,
      input  o_sum, o_cnt, o_ovf, o_valid
   );

   modport slave (
      input  i_ce, i_p, i_aux, i_flush,
      output o_sum, o_cnt, o_ovf, o_valid
   );
endinterface

// File: rtl/umpy_accum.sv
// Frame accumulator for the umpy_NxM product stream.
// Sums every product of a frame (i_aux marks the first product) into a saturating NACC-bit
// accumulator and emits the reduced sum, product count and sticky overflow two ce-edges after
// the frame ends.
// Optional feature: define UMPY_ACCUM_ROUND_EN to reduce the sum with convergent rounding
// (round half to even) instead of truncation.
module umpy_accum #(
   parameter int unsigned NP    = 24,
   parameter int unsigned NACC  = 32,
   parameter int unsigned OW    = 16,
   parameter int unsigned LGCNT = 8
) (
   input logic         i_clk,
   input logic         i_reset_n,
   umpy_accum_if.slave bus
);

   localparam int unsigned Drop = NACC - OW;

   typedef enum logic [0:0] {StIdle, StAccum} state_e;

   state_e state_q, state_d;

   // FSM control strobes, already qualified by i_ce
   logic start_frame, accumulate, dump;

   logic [NACC-1:0]  acc_q;
   logic [LGCNT-1:0] cnt_q;
   logic             ovf_q;

   logic [NACC-1:0]  hold_acc_q;
   logic [LGCNT-1:0] hold_cnt_q;
   logic             hold_ovf_q;
   logic             dump_q;

   logic [OW-1:0]    sum_q;
   logic [LGCNT-1:0] out_cnt_q;
   logic             out_ovf_q;
   logic             valid_q;

   logic [NACC:0]    add_full;
   logic [OW-1:0]    red_sum;

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a frame runs from i_aux until a lone i_flush
   always_comb begin
      state_d = state_q;
      if (bus.i_ce) begin
         unique case (state_q)
            StIdle: begin
               if (bus.i_aux) state_d = StAccum;
            end
            StAccum: begin
               if (!bus.i_aux && bus.i_flush) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Control decode: i_aux always wins over i_flush because it both ends and starts a frame
   always_comb begin
      start_frame = 1'b0;
      accumulate  = 1'b0;
      dump        = 1'b0;
      if (bus.i_ce) begin
         unique case (state_q)
            StIdle: begin
               start_frame = bus.i_aux;
            end
            StAccum: begin
               if (bus.i_aux) begin
                  dump        = 1'b1;
                  start_frame = 1'b1;
               end else if (bus.i_flush) begin
                  dump = 1'b1;
               end else begin
                  accumulate = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // One extra bit catches the carry that signals accumulator saturation
   assign add_full = {1'b0, acc_q} + {{(NACC + 1 - NP){1'b0}}, bus.i_p};

   // Running frame accumulator, count and sticky overflow
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (start_frame) begin
         acc_q <= NACC'(bus.i_p);
         cnt_q <= LGCNT'(1);
         ovf_q <= 1'b0;
      end else if (accumulate) begin
         if (add_full[NACC]) begin
            acc_q <= '1;
            ovf_q <= 1'b1;
         end else begin
            acc_q <= add_full[NACC-1:0];
         end
         if (cnt_q != '1) cnt_q <= cnt_q + LGCNT'(1);
      end
   end

   // Hold stage: snapshot of the finished frame, freeing the accumulator for the next one
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hold_acc_q <= '0;
         hold_cnt_q <= '0;
         hold_ovf_q <= 1'b0;
         dump_q     <= 1'b0;
      end else if (bus.i_ce) begin
         dump_q <= dump;
         if (dump) begin
            hold_acc_q <= acc_q;
            hold_cnt_q <= cnt_q;
            hold_ovf_q <= ovf_q;
         end
      end
   end

   // Reduction of the held sum to OW bits
   if (Drop == 0) begin : g_pass
      assign red_sum = hold_acc_q[OW-1:0];
   end else begin : g_reduce
`ifdef UMPY_ACCUM_ROUND_EN
      localparam logic [Drop-1:0] Half = Drop'(1) << (Drop - 1);
      logic [OW-1:0]   keep;
      logic [Drop-1:0] frac;
      logic            rnd_up;
      logic [OW:0]     rnd_sum;
      assign keep    = hold_acc_q[NACC-1 -: OW];
      assign frac    = hold_acc_q[Drop-1:0];
      // Exact halves go to the even neighbour
      assign rnd_up  = (frac > Half) || ((frac == Half) && keep[0]);
      assign rnd_sum = {1'b0, keep} + {{OW{1'b0}}, rnd_up};
      // Carry out of the rounding saturates the sum; it is not an accumulator overflow
      assign red_sum = rnd_sum[OW] ? '1 : rnd_sum[OW-1:0];
`else
      logic unused_lsbs;
      assign unused_lsbs = ^hold_acc_q[Drop-1:0];
      assign red_sum     = hold_acc_q[NACC-1 -: OW];
`endif
   end

   // Output stage: o_valid pulses for one ce-cycle, data keeps its last value otherwise
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sum_q     <= '0;
         out_cnt_q <= '0;
         out_ovf_q <= 1'b0;
         valid_q   <= 1'b0;
      end else if (bus.i_ce) begin
         valid_q <= dump_q;
         if (dump_q) begin
            sum_q     <= red_sum;
            out_cnt_q <= hold_cnt_q;
            out_ovf_q <= hold_ovf_q;
         end
      end
   end

   assign bus.o_sum   = sum_q;
   assign bus.o_cnt   = out_cnt_q;
   assign bus.o_ovf   = out_ovf_q;
   assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_umpy_accum.sv
// Directed bench for umpy_accum at default parameters; expectations follow UMPY_ACCUM_ROUND_EN.
module tb_umpy_accum;

`ifdef UMPY_ACCUM_ROUND_EN
   localparam bit Rnd = 1'b1;
`else
   localparam bit Rnd = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   umpy_accum_if #(.NP(24), .OW(16), .LGCNT(8)) bus ();

   umpy_accum #(.NP(24), .NACC(32), .OW(16), .LGCNT(8)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one ce-cycle of stimulus; outputs are stable 1ns after the edge
   task automatic step(input logic ce, input logic [23:0] p, input logic aux, input logic flush);
      bus.i_ce    = ce;
      bus.i_p     = p;
      bus.i_aux   = aux;
      bus.i_flush = flush;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [15:0] sum, input logic [7:0] cnt,
                            input logic ovf);
      check({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
      check({tag, ".sum"},   32'(bus.o_sum),   32'(sum));
      check({tag, ".cnt"},   32'(bus.o_cnt),   32'(cnt));
      check({tag, ".ovf"},   32'(bus.o_ovf),   32'(ovf));
   endtask

   // End the running frame with i_flush and check the result two edges later
   task automatic flush_check(input string tag, input logic [15:0] sum, input logic [7:0] cnt,
                              input logic ovf);
      step(1'b1, 24'h0, 1'b0, 1'b1);
      check({tag, ".lat1"}, 32'(bus.o_valid), 32'd0);
      step(1'b1, 24'h0, 1'b0, 1'b0);
      check_out(tag, sum, cnt, ovf);
      step(1'b1, 24'h0, 1'b0, 1'b0);
      check({tag, ".drop"}, 32'(bus.o_valid), 32'd0);
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      rst_n       = 1'b0;
      bus.i_ce    = 1'b0;
      bus.i_p     = '0;
      bus.i_aux   = 1'b0;
      bus.i_flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.valid", 32'(bus.o_valid), 32'd0);
      check("rst.sum",   32'(bus.o_sum),   32'd0);
      check("rst.cnt",   32'(bus.o_cnt),   32'd0);
      check("rst.ovf",   32'(bus.o_ovf),   32'd0);
      rst_n = 1'b1;
      step(1'b1, 24'h0, 1'b0, 1'b0);

      // Basic frame and latency: 0x8000 + 0x8000 = 0x10000 -> 0x0001
      step(1'b1, 24'h008000, 1'b1, 1'b0);
      step(1'b1, 24'h008000, 1'b0, 1'b0);
      step(1'b1, 24'h000000, 1'b1, 1'b0);
      check("lat.edge1", 32'(bus.o_valid), 32'd0);
      step(1'b1, 24'h000000, 1'b0, 1'b0);
      check_out("frame", 16'h0001, 8'd2, 1'b0);
      step(1'b1, 24'h000000, 1'b0, 1'b0);
      check("frame.drop", 32'(bus.o_valid), 32'd0);
      // Frame started by the last i_aux holds 0+0+0 over three products
      flush_check("zero", 16'h0000, 8'd3, 1'b0);

      // Rounding: 0x18000, 0x28000, 0xFFFF8000
      step(1'b1, 24'h008000, 1'b1, 1'b0);
      step(1'b1, 24'h010000, 1'b0, 1'b0);
      flush_check("rnd18", Rnd ? 16'h0002 : 16'h0001, 8'd2, 1'b0);
      step(1'b1, 24'h008000, 1'b1, 1'b0);
      step(1'b1, 24'h020000, 1'b0, 1'b0);
      flush_check("rnd28", 16'h0002, 8'd2, 1'b0);
      // 255 * 0xFFFFFF + 0xFF80FF = 0xFFFF8000, 256 products saturate the counter
      step(1'b1, 24'hFFFFFF, 1'b1, 1'b0);
      repeat (254) step(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
      step(1'b1, 24'hFF80FF, 1'b0, 1'b0);
      flush_check("rndtop", 16'hFFFF, 8'hFF, 1'b0);

      // Saturation: 257 * 0xFFFFFF overflows 32 bits
      step(1'b1, 24'hFFFFFF, 1'b1, 1'b0);
      repeat (256) step(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
      flush_check("sat", 16'hFFFF, 8'hFF, 1'b1);

      // Back in IDLE: stray products and a lone flush produce nothing
      step(1'b1, 24'h123456, 1'b0, 1'b0);
      step(1'b1, 24'h000000, 1'b0, 1'b1);
      step(1'b1, 24'h123456, 1'b0, 1'b0);
      check("idle.a", 32'(bus.o_valid), 32'd0);
      step(1'b1, 24'h000000, 1'b0, 1'b0);
      check("idle.b", 32'(bus.o_valid), 32'd0);

      // i_aux with i_flush: frame A (0x40000) emitted, frame B (0x50000) keeps running
      step(1'b1, 24'h030000, 1'b1, 1'b0);
      step(1'b1, 24'h010000, 1'b0, 1'b0);
      step(1'b1, 24'h050000, 1'b1, 1'b1);
      check("auxfl.edge1", 32'(bus.o_valid), 32'd0);
      step(1'b1, 24'h000000, 1'b0, 1'b1);
      check_out("auxfl.a", 16'h0004, 8'd2, 1'b0);
      step(1'b1, 24'h000000, 1'b0, 1'b0);
      check_out("auxfl.b", 16'h0005, 8'd1, 1'b0);
      step(1'b1, 24'h000000, 1'b0, 1'b0);
      check("auxfl.drop", 32'(bus.o_valid), 32'd0);

      // i_ce low for 3 cycles after a dump defers the result
      step(1'b1, 24'h070000, 1'b1, 1'b0);
      step(1'b1, 24'h000000, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 24'hABCDEF, 1'b1, 1'b0);
         check("ce.hold.valid", 32'(bus.o_valid), 32'd0);
         check("ce.hold.sum",   32'(bus.o_sum),   32'h0005);
      end
      step(1'b1, 24'h000000, 1'b0, 1'b0);
      check_out("ce.out", 16'h0007, 8'd1, 1'b0);
      step(1'b0, 24'h000000, 1'b0, 1'b0);
      check("ce.valid.hold", 32'(bus.o_valid), 32'd1);
      step(1'b1, 24'h000000, 1'b0, 1'b0);
      check("ce.drop", 32'(bus.o_valid), 32'd0);

      // Back-to-back single-product frames then reset with a dump pending
      step(1'b1, 24'h010000, 1'b1, 1'b0);
      step(1'b1, 24'h020000, 1'b1, 1'b0);
      step(1'b1, 24'h030000, 1'b1, 1'b0);
      check_out("b2b.1", 16'h0001, 8'd1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst2.valid", 32'(bus.o_valid), 32'd0);
      check("rst2.sum",   32'(bus.o_sum),   32'd0);
      check("rst2.cnt",   32'(bus.o_cnt),   32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 24'h000000, 1'b0, 1'b0);
      check("rst2.nopend.a", 32'(bus.o_valid), 32'd0);
      step(1'b1, 24'h000000, 1'b0, 1'b1);
      check("rst2.nopend.b", 32'(bus.o_valid), 32'd0);
      step(1'b1, 24'h000000, 1'b0, 1'b0);
      check("rst2.nopend.c", 32'(bus.o_valid), 32'd0);
      step(1'b1, 24'h010000, 1'b1, 1'b0);
      flush_check("post", 16'h0001, 8'd1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
